// File: rtl/huffman_code_table_if.sv
// huffman_code_table_if: control, write and read-lane signals of the Huffman code table
// Ports (signals): ctrl_clear/ctrl_ready/ctrl_write control, wr_sym/wr_code/wr_len write port,
// rd_req/rd_sym request and rd_valid/rd_hit/rd_code/rd_len response per read lane,
// num_entries live entry count, wr_err sticky illegal-write flag.
// master = tree-builder/bit-packer side, slave = table side.
interface huffman_code_table_if #(
    parameter int SYM_W  = 7,
    parameter int CODE_W = 128,
    parameter int NUM_RD = 2
);
    localparam int LEN_W = $clog2(CODE_W + 1);
    logic                     ctrl_clear;
    logic                     ctrl_ready;
    logic                     ctrl_write;
    logic [SYM_W-1:0]         wr_sym;
    logic [CODE_W-1:0]        wr_code;
    logic [LEN_W-1:0]         wr_len;
    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*SYM_W-1:0]  rd_sym;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD-1:0]        rd_hit;
    logic [NUM_RD*CODE_W-1:0] rd_code;
    logic [NUM_RD*LEN_W-1:0]  rd_len;
    logic [SYM_W:0]           num_entries;
    logic                     wr_err;

    modport master (
        output ctrl_clear, ctrl_write, wr_sym, wr_code, wr_len, rd_req, rd_sym,
        input  ctrl_ready, rd_valid, rd_hit, rd_code, rd_len, num_entries, wr_err
    );
    modport slave (
        input  ctrl_clear, ctrl_write, wr_sym, wr_code, wr_len, rd_req, rd_sym,
        output ctrl_ready, rd_valid, rd_hit, rd_code, rd_len, num_entries, wr_err
    );
endinterface

// File: rtl/huffman_code_table.sv
// huffman_code_table: symbol -> {code, length} lookup with one write port and NUM_RD registered read ports
// Ports: clk, ctrl_reset_n (async active-low), bus (huffman_code_table_if.slave).
// Entries carry valid bits; num_entries counts valid entries; reads are write-first.
// ctrl_clear invalidates everything at once, then zeroes storage one address per cycle
// while ctrl_ready is low.
// Optional: define HCT_LEN_CHECK_EN to reject writes with a bad length or stray code bits
// above the length (sticky wr_err); otherwise wr_err is 0.
module huffman_code_table #(
    parameter int SYM_W  = 7,
    parameter int CODE_W = 128,
    parameter int NUM_RD = 2
) (
    input logic clk,
    input logic ctrl_reset_n,
    huffman_code_table_if.slave bus
);
    localparam int LEN_W = $clog2(CODE_W + 1);
    localparam int DEPTH = 1 << SYM_W;

    typedef enum logic {IDLE, CLEAR} stateT;
    stateT state, nextState;

    logic [CODE_W+LEN_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]        valid;
    logic [SYM_W:0]          numEntries;
    logic [SYM_W-1:0]        clrAddr;
    logic                    clrGo, wrTry, wrOk, lenBad;

    assign clrGo = state == IDLE && bus.ctrl_clear;
    // clear wins over a same-edge write
    assign wrTry = state == IDLE && bus.ctrl_write && !bus.ctrl_clear;
`ifdef HCT_LEN_CHECK_EN
    assign lenBad = bus.wr_len == '0 || bus.wr_len > LEN_W'(CODE_W) || |(bus.wr_code >> bus.wr_len);
`else
    assign lenBad = 1'b0;
`endif
    assign wrOk = wrTry && !lenBad;
    assign bus.ctrl_ready  = state == IDLE;
    assign bus.num_entries = numEntries;

    always_ff @(posedge clk or negedge ctrl_reset_n)
        if (!ctrl_reset_n) state <= IDLE;
        else state <= nextState;

    always_comb begin
        nextState = state;
        nextState = state == IDLE ? (bus.ctrl_clear ? CLEAR : IDLE) : (&clrAddr ? IDLE : CLEAR);
    end

    always_ff @(posedge clk or negedge ctrl_reset_n)
        if (!ctrl_reset_n) begin
            valid      <= '0;
            numEntries <= '0;
            clrAddr    <= '0;
        end else if (clrGo) begin
            valid      <= '0;
            numEntries <= '0;
            clrAddr    <= '0;
        end else begin
            if (state == CLEAR) clrAddr <= clrAddr + 1'b1;
            if (wrOk) begin
                valid[bus.wr_sym] <= 1'b1;
                numEntries        <= numEntries + {{SYM_W{1'b0}}, ~valid[bus.wr_sym]};
            end
        end

    // storage has no reset: invalid entries are masked on read
    always_ff @(posedge clk)
        if (wrOk) mem[bus.wr_sym] <= {bus.wr_len, bus.wr_code};
        else if (state == CLEAR) mem[clrAddr] <= '0;

`ifdef HCT_LEN_CHECK_EN
    logic errFlag;
    always_ff @(posedge clk or negedge ctrl_reset_n)
        if (!ctrl_reset_n) errFlag <= 1'b0;
        else if (clrGo) errFlag <= 1'b0;
        else if (wrTry && lenBad) errFlag <= 1'b1;
    assign bus.wr_err = errFlag;
`else
    assign bus.wr_err = 1'b0;
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [SYM_W-1:0]        sym;
        logic                    byp, hit, vQ, hQ;
        logic [CODE_W+LEN_W-1:0] word;
        logic [CODE_W-1:0]       cQ;
        logic [LEN_W-1:0]        lQ;
        assign sym  = bus.rd_sym[p*SYM_W +: SYM_W];
        assign byp  = wrOk && bus.wr_sym == sym;
        assign hit  = byp || valid[sym];
        assign word = byp ? {bus.wr_len, bus.wr_code} : valid[sym] ? mem[sym] : '0;
        always_ff @(posedge clk or negedge ctrl_reset_n)
            if (!ctrl_reset_n) begin
                vQ <= 1'b0;
                hQ <= 1'b0;
                cQ <= '0;
                lQ <= '0;
            end else begin
                vQ <= bus.rd_req[p];
                if (bus.rd_req[p]) {hQ, lQ, cQ} <= {hit, word};
            end
        assign bus.rd_valid[p]                 = vQ;
        assign bus.rd_hit[p]                   = hQ;
        assign bus.rd_code[p*CODE_W +: CODE_W] = cQ;
        assign bus.rd_len[p*LEN_W +: LEN_W]    = lQ;
    end
endmodule

// File: tb/tb_huffman_code_table.sv
// tb_huffman_code_table: directed bench with an array-based reference model of the code table
module tb_huffman_code_table;
    localparam int SYM_W  = 7;
    localparam int CODE_W = 128;
    localparam int NUM_RD = 2;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    huffman_code_table_if #(.SYM_W(SYM_W), .CODE_W(CODE_W), .NUM_RD(NUM_RD)) bus();
    huffman_code_table #(.SYM_W(SYM_W), .CODE_W(CODE_W), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .ctrl_reset_n(rst_n), .bus(bus)
    );

    int errs = 0;
    int checks = 0;

    bit                mValid [DEPTH];
    logic [CODE_W-1:0] mCode [DEPTH];
    logic [LEN_W-1:0]  mLen [DEPTH];
    int                mCount, mBusy;
    bit                mErr;
    bit                eVal [NUM_RD];
    bit                eHit [NUM_RD];
    logic [CODE_W-1:0] eCode [NUM_RD];
    logic [LEN_W-1:0]  eLen [NUM_RD];

    task automatic chk(string nm, logic [159:0] got, logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic mreset();
        foreach (mValid[i]) mValid[i] = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            eVal[p] = 1'b0; eHit[p] = 1'b0; eCode[p] = '0; eLen[p] = '0;
        end
        mCount = 0; mBusy = 0; mErr = 1'b0;
    endtask

`ifdef HCT_LEN_CHECK_EN
    function automatic bit legal(logic [CODE_W-1:0] c, logic [LEN_W-1:0] l);
        if (l == 0 || l > CODE_W) return 1'b0;
        for (int i = 0; i < CODE_W; i++) if (i >= int'(l) && c[i]) return 1'b0;
        return 1'b1;
    endfunction
`endif

    // one clock: predict from the inputs now applied, advance past the edge, commit
    task automatic cyc();
        bit clr, wr, ok;
        bit rq [NUM_RD];
        bit hh [NUM_RD];
        logic [CODE_W-1:0] cc [NUM_RD];
        logic [LEN_W-1:0]  ll [NUM_RD];
        logic [SYM_W-1:0]  s, ws;
        logic [CODE_W-1:0] wc;
        logic [LEN_W-1:0]  wl;
        clr = 0; wr = 0; ok = 0;
        ws = bus.wr_sym; wc = bus.wr_code; wl = bus.wr_len;
        for (int p = 0; p < NUM_RD; p++) begin
            rq[p] = bus.rd_req[p]; hh[p] = 0; cc[p] = '0; ll[p] = '0;
        end
        if (rst_n) begin
            clr = mBusy == 0 && bus.ctrl_clear;
            wr  = mBusy == 0 && bus.ctrl_write && !bus.ctrl_clear;
            ok  = wr;
`ifdef HCT_LEN_CHECK_EN
            ok  = wr && legal(wc, wl);
`endif
            for (int p = 0; p < NUM_RD; p++) begin
                s = bus.rd_sym[p*SYM_W +: SYM_W];
                if (ok && ws == s) begin hh[p] = 1; cc[p] = wc; ll[p] = wl; end
                else if (mValid[s]) begin hh[p] = 1; cc[p] = mCode[s]; ll[p] = mLen[s]; end
            end
        end
        @(posedge clk);
        if (rst_n) begin
            for (int p = 0; p < NUM_RD; p++) begin
                eVal[p] = rq[p];
                if (rq[p]) begin eHit[p] = hh[p]; eCode[p] = cc[p]; eLen[p] = ll[p]; end
            end
            if (mBusy > 0) mBusy--;
            if (clr) begin
                foreach (mValid[i]) mValid[i] = 1'b0;
                mCount = 0; mBusy = DEPTH; mErr = 1'b0;
            end else if (ok) begin
                if (!mValid[ws]) mCount++;
                mValid[ws] = 1'b1; mCode[ws] = wc; mLen[ws] = wl;
            end else if (wr) mErr = 1'b1;
        end
        #1;
    endtask

    task automatic wr(int s, logic [CODE_W-1:0] c, int l);
        bus.ctrl_write = 1'b1; bus.wr_sym = s[SYM_W-1:0]; bus.wr_code = c; bus.wr_len = l[LEN_W-1:0];
        cyc();
        bus.ctrl_write = 1'b0;
    endtask

    task automatic rdset(int p, int s);
        bus.rd_req[p] = 1'b1;
        bus.rd_sym[p*SYM_W +: SYM_W] = s[SYM_W-1:0];
    endtask

    always @(negedge clk) if (rst_n) begin
        chk("ctrl_ready", bus.ctrl_ready, mBusy == 0);
        chk("num_entries", bus.num_entries, mCount);
        chk("wr_err", bus.wr_err, mErr);
        for (int p = 0; p < NUM_RD; p++) begin
            chk("rd_valid", bus.rd_valid[p], eVal[p]);
            chk("rd_hit", bus.rd_hit[p], eHit[p]);
            chk("rd_code", bus.rd_code[p*CODE_W +: CODE_W], eCode[p]);
            chk("rd_len", bus.rd_len[p*LEN_W +: LEN_W], eLen[p]);
        end
    end

    initial begin
        int n, lowCnt;
        bit anyHit;
        bus.ctrl_clear = 0; bus.ctrl_write = 0; bus.wr_sym = '0; bus.wr_code = '0; bus.wr_len = '0;
        bus.rd_req = '0; bus.rd_sym = '0;
        mreset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", bus.ctrl_ready, 1);
        chk("reset_num", bus.num_entries, 0);

        // empty-table read
        rdset(0, 5); cyc(); bus.rd_req = '0;
        @(negedge clk);
        chk("t1_valid", bus.rd_valid[0], 1);
        chk("t1_hit", bus.rd_hit[0], 0);
        chk("t1_code", bus.rd_code[CODE_W-1:0], 0);
        chk("t1_len", bus.rd_len[LEN_W-1:0], 0);

        // write then dual-port read, then overwrite
        wr(65, 'hB, 4);
        rdset(0, 65); rdset(1, 65); cyc(); bus.rd_req = '0;
        @(negedge clk);
        chk("t2_hit", bus.rd_hit, 2'b11);
        chk("t2_code0", bus.rd_code[CODE_W-1:0], 'hB);
        chk("t2_code1", bus.rd_code[2*CODE_W-1:CODE_W], 'hB);
        chk("t2_len1", bus.rd_len[2*LEN_W-1:LEN_W], 4);
        chk("t2_num", bus.num_entries, 1);
        wr(65, 'h2, 2);
        @(negedge clk);
        chk("t2_renum", bus.num_entries, 1);
        rdset(1, 65); cyc(); bus.rd_req = '0;
        @(negedge clk);
        chk("t2_recode", bus.rd_code[2*CODE_W-1:CODE_W], 'h2);

        // write-first bypass
        bus.ctrl_write = 1; bus.wr_sym = 3; bus.wr_code = 'h7; bus.wr_len = 3;
        rdset(1, 3); cyc(); bus.ctrl_write = 0; bus.rd_req = '0;
        @(negedge clk);
        chk("t3_hit", bus.rd_hit[1], 1);
        chk("t3_code", bus.rd_code[2*CODE_W-1:CODE_W], 'h7);
        chk("t3_len", bus.rd_len[2*LEN_W-1:LEN_W], 3);

        // bulk load then clear; writes and a second clear inside the window are ignored
        for (int i = 0; i < 10; i++) wr(10 + i, CODE_W'(i + 1), 4);
        @(negedge clk);
        chk("t4_loaded", bus.num_entries, 12);
        bus.ctrl_clear = 1; cyc(); bus.ctrl_clear = 0;
        @(negedge clk);
        chk("t4_num0", bus.num_entries, 0);
        lowCnt = bus.ctrl_ready ? 0 : 1;
        bus.ctrl_write = 1; bus.wr_sym = 20; bus.wr_code = 1; bus.wr_len = 1;
        n = 0;
        while (!bus.ctrl_ready && n < 300) begin
            bus.ctrl_clear = (n == 50);
            rdset(0, n % DEPTH); rdset(1, (n + 64) % DEPTH);
            cyc(); n++;
            @(negedge clk);
            if (!bus.ctrl_ready) lowCnt++;
        end
        bus.ctrl_write = 0; bus.ctrl_clear = 0; bus.rd_req = '0;
        chk("t4_low_cycles", lowCnt, 128);
        chk("t4_num_after", bus.num_entries, 0);
        anyHit = 0;
        for (int i = 0; i < 64; i++) begin
            rdset(0, i); rdset(1, i + 64); cyc();
            @(negedge clk);
            anyHit |= |bus.rd_hit;
        end
        bus.rd_req = '0;
        chk("t4_any_hit", anyHit, 0);

`ifdef HCT_LEN_CHECK_EN
        wr(30, 'h0, 0);
        wr(31, 'h10, 4);
        @(negedge clk);
        chk("t5_err", bus.wr_err, 1);
        chk("t5_num", bus.num_entries, 0);
        wr(32, 'h1, 129);
        @(negedge clk);
        chk("t5_num129", bus.num_entries, 0);
        bus.ctrl_clear = 1; cyc(); bus.ctrl_clear = 0;
        @(negedge clk);
        chk("t5_err_cleared", bus.wr_err, 0);
        n = 0;
        while (!bus.ctrl_ready && n < 300) begin cyc(); n++; @(negedge clk); end
        chk("t5_clear_done", bus.ctrl_ready, 1);
`else
        wr(30, 'h10, 0);
        @(negedge clk);
        chk("t5_stored", bus.num_entries, 1);
        chk("t5_err", bus.wr_err, 0);
`endif

        // reset in the middle of a clear
        wr(9, 'h55, 7);
        rdset(0, 9); cyc(); bus.rd_req = '0;
        bus.ctrl_clear = 1; cyc(); bus.ctrl_clear = 0;
        repeat (40) cyc();
        @(negedge clk);
        chk("t6_hold", bus.rd_code[CODE_W-1:0], 'h55);
        chk("t6_busy", bus.ctrl_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_ready", bus.ctrl_ready, 1);
        chk("t6_valid", bus.rd_valid, 0);
        chk("t6_hit", bus.rd_hit, 0);
        chk("t6_code", bus.rd_code, 0);
        chk("t6_len", bus.rd_len, 0);
        chk("t6_num", bus.num_entries, 0);
        chk("t6_err", bus.wr_err, 0);
        mreset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr(7, 'h3, 2);
        rdset(0, 7); cyc(); bus.rd_req = '0;
        @(negedge clk);
        chk("t6_after_num", bus.num_entries, 1);
        chk("t6_after_hit", bus.rd_hit[0], 1);
        chk("t6_after_code", bus.rd_code[CODE_W-1:0], 'h3);
        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
